bus_responder: RTL



---
 rtl/bus_map_pkg.sv | 23 ++
 rtl/responder_timer.sv | 83 ++++++++
 rtl/bus_responder.sv | 102 ++++++++++
 3 files changed

// File: rtl/bus_map_pkg.sv
// Address map constants and decode target type shared by the bus responder
// and its timer sub-block.
package bus_map_pkg;

    localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h1001_0000;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1002_0000;

    localparam logic [1:0] GPIO_OFS   = 2'd0;
    localparam logic [1:0] COUNT_OFS  = 2'd1;
    localparam logic [1:0] CMP_OFS    = 2'd2;
    localparam logic [1:0] STATUS_OFS = 2'd3;

    localparam int STATUS_MATCH_BIT  = 0;
    localparam int STATUS_EN_BIT     = 1;
    localparam int STATUS_IRQ_EN_BIT = 2;

    typedef enum logic [1:0] {
        TGT_RAM,
        TGT_MMIO,
        TGT_NONE
    } bus_target_t;

endpackage

// File: rtl/responder_timer.sv
// Auto-reload compare timer: COUNT/CMP/STATUS registers, reload on match,
// sticky MATCH with write-1-to-clear where a hardware set wins.
module responder_timer
    import bus_map_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_count,
    input  logic        i_wr_cmp,
    input  logic        i_wr_status,
    input  logic [31:0] i_wr_data,
    input  logic [1:0]  i_rd_sel,
    output logic [31:0] o_rd_data,
    output logic        o_irq
);

    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_match;
    logic        r_en;
    logic        r_irq_en;

    logic        w_hit;
    logic [31:0] w_count_next;
    logic        w_match_next;

    // A bus write to COUNT overrides both reload and increment.
    always_comb begin
        w_hit        = r_en && (r_count == r_cmp);
        w_count_next = r_count;
        if (i_wr_count) begin
            w_count_next = i_wr_data;
        end else if (w_hit) begin
            w_count_next = 32'd0;
        end else if (r_en) begin
            w_count_next = r_count + 32'd1;
        end

        w_match_next = r_match;
        if (w_hit) begin
            w_match_next = 1'b1;
        end else if (i_wr_status && i_wr_data[STATUS_MATCH_BIT]) begin
            w_match_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count  <= 32'd0;
            r_cmp    <= 32'hFFFF_FFFF;
            r_match  <= 1'b0;
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_match <= w_match_next;
            if (i_wr_cmp) begin
                r_cmp <= i_wr_data;
            end
            if (i_wr_status) begin
                r_en     <= i_wr_data[STATUS_EN_BIT];
                r_irq_en <= i_wr_data[STATUS_IRQ_EN_BIT];
            end
        end
    end

    always_comb begin
        o_rd_data = 32'd0;
        case (i_rd_sel)
            COUNT_OFS: o_rd_data = r_count;
            CMP_OFS:   o_rd_data = r_cmp;
            STATUS_OFS: begin
                o_rd_data[STATUS_MATCH_BIT]  = r_match;
                o_rd_data[STATUS_EN_BIT]     = r_en;
                o_rd_data[STATUS_IRQ_EN_BIT] = r_irq_en;
            end
            default: o_rd_data = 32'd0;
        endcase
    end

    assign o_irq = r_match & r_irq_en;

endmodule

// File: rtl/bus_responder.sv
// Slave end of the core's shared bus: decodes each access to data RAM, the
// GPIO/timer MMIO block or unmapped space, with a registered read port.
module bus_responder
    import bus_map_pkg::*;
#(
    parameter int          RAM_ADDR_WIDTH = 10,
    parameter logic [31:0] RAM_BASE       = RAM_BASE_DEFAULT,
    parameter logic [31:0] MMIO_BASE      = MMIO_BASE_DEFAULT,
    parameter int          GPIO_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           bus_addr,
    input  logic [31:0]           bus_wrdata,
    input  logic                  bus_wren,
    input  logic                  bus_rden,
    output logic [31:0]           bus_rddata,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  timer_irq
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

    // Handshake: wren/rden are single-cycle strobes that are always accepted
    // (no stall); read data appears the cycle after rden and holds until the
    // next read or reset.
    logic [31:0]               r_ram [0:RAM_DEPTH-1];
    logic [31:0]               r_gpio;
    logic [31:0]               r_rddata;

    bus_target_t               w_target;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
    logic [1:0]                w_reg_sel;
    logic                      w_ram_wr;
    logic                      w_mmio_wr;
    logic [31:0]               w_timer_rd;
    logic [31:0]               w_rd_mux;
    logic                      w_unused_addr;

    assign w_unused_addr = ^bus_addr[1:0];
    assign w_ram_idx     = bus_addr[RAM_ADDR_WIDTH+1:2];
    assign w_reg_sel     = bus_addr[3:2];

    always_comb begin
        w_target = TGT_NONE;
        if (bus_addr[31:RAM_ADDR_WIDTH+2] == RAM_BASE[31:RAM_ADDR_WIDTH+2]) begin
            w_target = TGT_RAM;
        end else if (bus_addr[31:4] == MMIO_BASE[31:4]) begin
            w_target = TGT_MMIO;
        end
    end

    assign w_ram_wr  = bus_wren && (w_target == TGT_RAM);
    assign w_mmio_wr = bus_wren && (w_target == TGT_MMIO);

    responder_timer u_timer (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_count  (w_mmio_wr && (w_reg_sel == COUNT_OFS)),
        .i_wr_cmp    (w_mmio_wr && (w_reg_sel == CMP_OFS)),
        .i_wr_status (w_mmio_wr && (w_reg_sel == STATUS_OFS)),
        .i_wr_data   (bus_wrdata),
        .i_rd_sel    (w_reg_sel),
        .o_rd_data   (w_timer_rd),
        .o_irq       (timer_irq)
    );

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_ram[w_ram_idx] <= bus_wrdata;
        end
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_target)
            TGT_RAM:  w_rd_mux = r_ram[w_ram_idx];
            TGT_MMIO: w_rd_mux = (w_reg_sel == GPIO_OFS) ? r_gpio : w_timer_rd;
            default:  w_rd_mux = 32'd0;
        endcase
    end

    // The mux sees pre-edge state, so a same-cycle write returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio   <= 32'd0;
            r_rddata <= 32'd0;
        end else begin
            if (w_mmio_wr && (w_reg_sel == GPIO_OFS)) begin
                r_gpio <= bus_wrdata;
            end
            if (bus_rden) begin
                r_rddata <= w_rd_mux;
            end
        end
    end

    assign bus_rddata = r_rddata;
    assign gpio_out   = r_gpio[GPIO_WIDTH-1:0];

endmodule
